// File: rtl/i2s_tx.sv
// I2S transmitter: divides clk_i down to sclk_o and serialises one buffered
// stereo sample pair per 64-slot frame, MSB first with the one-bit I2S delay.
module i2s_tx #(
  parameter int width_p     = 24,
  parameter int sclk_half_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [width_p-1:0] left_i,
  input  logic [width_p-1:0] right_i,
  output logic               sclk_o,
  output logic               lrck_o,
  output logic               sdata_o,
  output logic               underrun_o
);

  localparam int              DW       = (sclk_half_p > 1) ? $clog2(sclk_half_p) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(sclk_half_p - 1);
  localparam int              IW       = $clog2(width_p);
  localparam logic [5:0]      W6       = 6'(width_p);

  logic [DW-1:0]      div_q;
  logic [5:0]         slot_q;
  logic [5:0]         slot_nx;
  logic [width_p-1:0] buf_l;
  logic [width_p-1:0] buf_r;
  logic [width_p-1:0] frm_l;
  logic [width_p-1:0] frm_r;
  logic               buf_full;
  logic               fall;
  logic               load;
  logic               accept;
  logic               bit_nx;
  logic [IW-1:0]      idx;

  assign fall    = sclk_o && (div_q == DIV_LAST);
  assign slot_nx = slot_q + 6'd1;
  assign load    = fall && (slot_nx == 6'd0);
  assign accept  = valid_i && !buf_full;
  assign ready_o = !buf_full;

  // Bit for the slot being entered; slot 0 and padding slots carry zero.
  always_comb begin
    bit_nx = 1'b0;
    idx    = '0;
    if (slot_nx != 6'd0 && slot_nx <= W6) begin
      idx    = IW'(W6 - slot_nx);
      bit_nx = frm_l[idx];
    end else if (slot_nx > 6'd32 && slot_nx <= 6'd32 + W6) begin
      idx    = IW'(W6 + 6'd32 - slot_nx);
      bit_nx = frm_r[idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q      <= '0;
      sclk_o     <= 1'b0;
      slot_q     <= 6'd63;
      lrck_o     <= 1'b1;
      sdata_o    <= 1'b0;
      frm_l      <= '0;
      frm_r      <= '0;
      buf_l      <= '0;
      buf_r      <= '0;
      buf_full   <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      if (div_q == DIV_LAST) begin
        div_q  <= '0;
        sclk_o <= ~sclk_o;
      end else begin
        div_q <= div_q + DW'(1);
      end

      underrun_o <= load && !buf_full;

      if (fall) begin
        slot_q  <= slot_nx;
        lrck_o  <= slot_nx[5];
        sdata_o <= bit_nx;
      end

      if (load) begin
        frm_l <= buf_full ? buf_l : '0;
        frm_r <= buf_full ? buf_r : '0;
      end

      // A sample accepted on the load edge is held for the following frame.
      if (accept) begin
        buf_l    <= left_i;
        buf_r    <= right_i;
        buf_full <= 1'b1;
      end else if (load) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a timing/queue reference model derived from
// the frame arithmetic is compared against every DUT output each cycle.
module tb_i2s_tx;

  localparam int W = 24;
  localparam int H = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid;
  logic         ready;
  logic [W-1:0] left;
  logic [W-1:0] right;
  logic         sclk;
  logic         lrck;
  logic         sdata;
  logic         underrun;

  always #5 clk = ~clk;

  i2s_tx #(.width_p(W), .sclk_half_p(H)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .valid_i    (valid),
    .ready_o    (ready),
    .left_i     (left),
    .right_i    (right),
    .sclk_o     (sclk),
    .lrck_o     (lrck),
    .sdata_o    (sdata),
    .underrun_o (underrun)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: edges since reset, pending-sample queue, current frame.
  logic [2*W-1:0] pend_q[$];
  logic [W-1:0]   fl;
  logic [W-1:0]   fr;
  int             n;
  int             slot;
  bit             exp_und;
  bit             in_reset;
  bit             acc;

  function automatic logic exp_sdata();
    if (slot >= 1 && slot <= W) return fl[W - slot];
    if (slot >= 33 && slot <= 32 + W) return fr[W - (slot - 32)];
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b (edge %0d slot %0d)", tag, obs, exp, n, slot);
    end
  endtask

  task automatic step();
    @(posedge clk);
    acc = 1'b0;
    if (reset) begin
      in_reset = 1'b1;
      n        = 0;
      pend_q.delete();
      fl       = '0;
      fr       = '0;
      slot     = 63;
      exp_und  = 1'b0;
    end else begin
      in_reset = 1'b0;
      acc      = valid && (pend_q.size() == 0);
      n++;
      exp_und  = 1'b0;
      if (n % (2*H) == 0) begin
        slot = (n / (2*H) - 1) % 64;
        if (slot == 0) begin
          if (pend_q.size() > 0) begin
            {fl, fr} = pend_q.pop_front();
          end else begin
            fl      = '0;
            fr      = '0;
            exp_und = 1'b1;
          end
        end
      end
      if (acc) pend_q.push_back({left, right});
    end
    #1;
    chk("sclk",     sclk,     in_reset ? 1'b0 : 1'(((n / H) % 2)));
    chk("lrck",     lrck,     1'(slot >= 32));
    chk("sdata",    sdata,    exp_sdata());
    chk("ready",    ready,    1'(pend_q.size() == 0));
    chk("underrun", underrun, exp_und);
  endtask

  initial begin
    logic [W-1:0] seq;
    bit           found;

    reset = 1'b1;
    valid = 1'b0;
    left  = '0;
    right = '0;
    n     = 0;
    slot  = 63;
    fl    = '0;
    fr    = '0;

    // Reset for two cycles, then one known sample pair in cycle 1.
    step();
    step();
    reset = 1'b0;
    valid = 1'b1;
    left  = 24'h800001;
    right = 24'h7FFFFE;
    step();
    tests++;
    assert (acc) else begin
      fails++;
      $error("FAIL first_accept: observed %b expected 1", acc);
    end
    valid = 1'b0;
    repeat (300) step();

    // Idle: underrun every frame, silent data.
    repeat (600) step();

    // Continuous valid with incrementing samples.
    seq   = W'(1);
    valid = 1'b1;
    for (int i = 0; i < 256 * 5; i++) begin
      left  = seq;
      right = seq;
      step();
      if (acc) seq = seq + W'(1);
    end
    valid = 1'b0;
    repeat (600) step();

    // Handshake exactly on the load edge with an empty buffer.
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (pend_q.size() == 0 && (n + 1) % (2*H) == 0 && ((n + 1) / (2*H) - 1) % 64 == 0)
        found = 1'b1;
      else
        step();
    end
    tests++;
    assert (found) else begin
      fails++;
      $error("FAIL find_load_edge: observed %b expected 1", found);
    end
    valid = 1'b1;
    left  = W'($urandom);
    right = W'($urandom);
    step();
    tests++;
    assert (acc && exp_und) else begin
      fails++;
      $error("FAIL load_edge_accept: observed %b expected 1", acc && exp_und);
    end
    valid = 1'b0;
    repeat (600) step();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 99) < 5);
      left  = W'($urandom);
      right = W'($urandom);
      step();
    end

    // Mid-frame reset at slot 10 with a sample buffered.
    valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      left  = W'($urandom);
      right = W'($urandom);
      if (slot == 10 && pend_q.size() > 0)
        found = 1'b1;
      else
        step();
    end
    tests++;
    assert (found) else begin
      fails++;
      $error("FAIL find_slot10: observed %b expected 1", found);
    end
    valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (600) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter width_p, default 24: bits per audio sample; legal range 8..31.
REQ-002 Parameter sclk_half_p, default 2: clk_i cycles per sclk_o half-period; legal range >= 1.
REQ-003 clk_i  input  1  system clock (12 MHz nominal); single clock domain.
REQ-004 reset_i  input  1  reset; synchronous to clk_i, active-high.
REQ-005 valid_i  input  1  stereo sample pair present on left_i/right_i.
REQ-006 ready_o  output  1  block can accept a sample pair this cycle.
REQ-007 left_i  input  width_p  signed left-channel sample.
REQ-008 right_i  input  width_p  signed right-channel sample.
REQ-009 sclk_o  output  1  I2S serial bit clock.
REQ-010 lrck_o  output  1  I2S word select; 0 = left, 1 = right.
REQ-011 sdata_o  output  1  I2S serial data, MSB first.
REQ-012 underrun_o  output  1  one-cycle pulse: a frame started with no buffered sample.

Function
REQ-013 The divider SHALL toggle sclk_o every sclk_half_p clk_i cycles, giving a period of 2*sclk_half_p cycles (defaults: 3 MHz sclk_o).
REQ-014 An "sclk fall" is the clk_i edge on which sclk_o goes 1->0; lrck_o, sdata_o and the slot counter SHALL change only on sclk falls.
REQ-015 A frame SHALL be 64 bit-slots (0..63); the slot counter advances by 1 on each sclk fall and wraps 63->0 (defaults: 256 clk_i cycles per frame, fs = 46875 Hz).
REQ-016 lrck_o SHALL be 0 during slots 0..31 and 1 during slots 32..63.
REQ-017 sdata_o SHALL be left[width_p-k] in slot k for k = 1..width_p; right[width_p-(k-32)] in slot k for k = 33..32+width_p; 0 in all other slots (one-bit I2S delay, zero padding).
REQ-018 The block SHALL contain a one-entry holding buffer; ready_o SHALL equal NOT(buffer full) as a registered state.
REQ-019 When valid_i and ready_o are both 1 on a clk_i edge, left_i/right_i SHALL be captured into the buffer, and ready_o SHALL be 0 from the next cycle.
REQ-020 On the sclk fall entering slot 0 with the buffer full, the buffer contents SHALL become the frame's left/right data and the buffer SHALL empty (ready_o = 1 the next cycle).
REQ-021 On the sclk fall entering slot 0 with the buffer empty, the frame data SHALL be all zeros and underrun_o SHALL be 1 for exactly that one clk_i cycle.
REQ-022 A handshake completing on the same edge as a frame load SHALL NOT feed that frame; the sample is buffered for the next frame, and a frame loaded from an empty buffer still signals underrun.
REQ-023 Frame data SHALL remain stable for all 64 slots regardless of later handshakes.
REQ-024 Sample order SHALL be preserved; no accepted sample is dropped or repeated except on reset.

Reset
REQ-025 While reset_i is 1 at a clk_i edge: sclk_o = 0, divider = 0, slot = 63, lrck_o = 1, sdata_o = 0, frame data = 0, buffer empty, ready_o = 1, underrun_o = 0.
REQ-026 Reset asserted mid-frame SHALL discard the buffered sample and the frame in progress; there is no partial-frame completion.
REQ-027 After reset_i deasserts, the first sclk fall SHALL occur on the 2*sclk_half_p-th clk_i edge and enter slot 0, performing a frame load per REQ-020/021.

Verification
REQ-028 Reset for 2 cycles -> sclk_o=0, lrck_o=1, sdata_o=0, ready_o=1, underrun_o=0; with defaults, first sclk fall on cycle 4, lrck_o->0.
REQ-029 After reset, present left=24'h800001, right=24'h7FFFFE with valid_i in cycle 1 -> accepted, ready_o=0 until the cycle-4 load; serial capture on sclk rises: slots 1..24 = 800001, 25..32 = 0, 33..56 = 7FFFFE, 57..63 = 0.
REQ-030 No valid_i after reset -> underrun_o pulses for one cycle at cycle 4, then every 256 cycles; sdata_o stays 0 throughout.
REQ-031 valid_i held high with an incrementing sample (1,2,3,...) -> exactly one accept per 256-cycle frame after the first, no underrun after the first frame, frames carry 1,2,3,... in order.
REQ-032 Handshake on the exact load edge with an empty buffer -> underrun pulse on that frame; the sample appears in the following frame.
REQ-033 reset_i asserted for 1 cycle at slot 10 with a sample buffered -> outputs return to REQ-025 values; the next frame is zeros with an underrun pulse.
